lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
// Receive-side companion to the 4-bit LFSR pattern generator. Samples the generator's parallel
// output word each valid beat, self-synchronises to the sequence, then predicts every next word.
// Flags and counts mismatches, and declares/drops lock. Used on the pattern-test path to verify
// LFSR streams in simulation and on the board.
// PARAMETERS
// WIDTH      4        LFSR word width
// TAPS       4'b1100  feedback tap mask; default gives x^4+x^3+1, maximal length 15
// LOCK_CNT   4        consecutive correct predictions needed to assert lock (>=1)
// UNLOCK_CNT 3        consecutive mismatches while locked that drop lock (>=1)
// CNT_W      8        error counter width
// PORTS
// clk        in   1      rising-edge clock
// reset      in   1      asynchronous, active-high reset
// din_valid  in   1      din is a new LFSR word this cycle
// din        in   WIDTH  received LFSR word (w)
// clear_cnt  in   1      synchronous clear of err_count
// locked     out  1      checker synchronised to the stream
// err        out  1      one-cycle pulse: mismatch on a beat sampled while locked
// err_count  out  CNT_W  saturating count of locked mismatches
// expected   out  WIDTH  predicted value of the next valid din word
// BEHAVIOUR
// - Next-state function: nxt(x) = {x[WIDTH-2:0], ^(x & TAPS)}.
//   With defaults: 1111->1110->1100->1000->0001->0010->0100->1001->0011->...
// - All-zero word is the lockup state; it is never used as a seed.
// - Reset (async): state=SEARCH; locked=0, err=0, err_count=0, expected=0; internal counters=0.
// - All outputs are registered. Nothing changes on cycles with din_valid=0,
//   except: err returns to 0, and clear_cnt still acts.
// - FSM, evaluated on cycles with din_valid=1:
//   SEARCH: if din!=0, expected<=nxt(din), match_cnt<=0, go to VERIFY. Otherwise stay; no error.
//   VERIFY, din==expected: match_cnt++ and expected<=nxt(din).
//     When this is the LOCK_CNT-th consecutive match, go to LOCKED and set locked<=1.
//   VERIFY, din!=expected: reseed. If din!=0: expected<=nxt(din), match_cnt<=0, stay in VERIFY.
//     If din==0: go to SEARCH. No err and no count while unlocked.
//   LOCKED: expected<=nxt(expected) always (flywheel; a single bad word does not reseed).
//     Match: bad_run<=0.
//     Mismatch: err<=1 next cycle, err_count+1 (saturates at all-ones), bad_run++.
//     When bad_run reaches UNLOCK_CNT: go to SEARCH, locked<=0. That final mismatch is still counted.
// - Latency: err and locked update in the cycle after the deciding beat is sampled.
// - clear_cnt with a same-cycle counted mismatch: err_count<=1 (clear, then count). clear_cnt alone: 0.
// - Saturation: at 2^CNT_W-1 further errors still pulse err; the count holds.
// - Reset mid-operation: immediate return to reset values, regardless of state.
// TESTING
// T1 reset: assert reset mid-stream while locked -> locked=0, err_count=0, expected=0 asynchronously.
// T2 acquire: defaults; feed 1111,1110,1100,1000,0001 one per beat -> locked=1 after the 5th beat;
//    expected=0010; err never asserted.
// T3 single error: locked; send 0000 in place of 0010, then 0100,1001 -> one err pulse;
//    err_count=1; locked stays 1.
// T4 unlock: locked; send 3 consecutive wrong words -> err_count+3; locked=0 after the 3rd;
//    a correct stream from seed 0001 relocks after 5 beats.
// T5 gaps/zero: din_valid toggled 1-0-1 between words -> same result as T2.
//    In SEARCH, din=0000 -> stays in SEARCH.
// T6 counter: CNT_W=2; force 5 locked errors (with relock) -> err_count=3 held.
//    clear_cnt coincident with an error -> err_count=1.

Source files
------------

// File: rtl/lfsr_checker_if.sv
// Stream bundle between an LFSR pattern source and the lfsr_checker.
// The source drives words and counter clears; the checker returns lock/error status.
interface lfsr_checker_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             clear_cnt;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_count;
    logic [WIDTH-1:0] expected;

    modport master (
        output din_valid, din, clear_cnt,
        input  locked, err, err_count, expected
    );

    modport slave (
        input  din_valid, din, clear_cnt,
        output locked, err, err_count, expected
    );
endinterface

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: seeds from the stream, verifies LOCK_CNT predictions, then
// flywheels while locked, pulsing err and counting mismatches until UNLOCK_CNT in a row.
module lfsr_checker #(
    parameter int unsigned       WIDTH      = 4,
    parameter logic [WIDTH-1:0]  TAPS       = 4'b1100,
    parameter int unsigned       LOCK_CNT   = 4,
    parameter int unsigned       UNLOCK_CNT = 3,
    parameter int unsigned       CNT_W      = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    lfsr_checker_if.slave io_bus
);
    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);
    localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [MW-1:0]    MATCH_ONE  = MW'(1);
    localparam logic [BW-1:0]    BAD_LAST   = BW'(UNLOCK_CNT - 1);
    localparam logic [BW-1:0]    BAD_ONE    = BW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_expected, w_expected_d;
    logic [MW-1:0]    r_match_cnt, w_match_cnt_d;
    logic [BW-1:0]    r_bad_run, w_bad_run_d;
    logic             r_locked, w_locked_d;
    logic             r_err, w_err_d;
    logic [CNT_W-1:0] r_err_count, w_err_count_d;
    logic [CNT_W-1:0] w_cnt_base;
    logic             w_count_err;

    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], ^(x & TAPS)};
    endfunction

    always_comb begin
        w_state_d     = r_state;
        w_expected_d  = r_expected;
        w_match_cnt_d = r_match_cnt;
        w_bad_run_d   = r_bad_run;
        w_locked_d    = r_locked;
        w_err_d       = 1'b0;
        w_count_err   = 1'b0;

        if (io_bus.din_valid) begin
            unique case (r_state)
                StSearch: begin
                    if (io_bus.din != '0) begin
                        w_expected_d  = nxt(io_bus.din);
                        w_match_cnt_d = '0;
                        w_state_d     = StVerify;
                    end
                end
                StVerify: begin
                    if (io_bus.din == r_expected) begin
                        w_expected_d  = nxt(io_bus.din);
                        w_match_cnt_d = r_match_cnt + MATCH_ONE;
                        if (r_match_cnt == MATCH_LAST) begin
                            w_state_d     = StLocked;
                            w_locked_d    = 1'b1;
                            w_match_cnt_d = '0;
                            w_bad_run_d   = '0;
                        end
                    end else if (io_bus.din != '0) begin
                        w_expected_d  = nxt(io_bus.din);
                        w_match_cnt_d = '0;
                    end else begin
                        w_match_cnt_d = '0;
                        w_state_d     = StSearch;
                    end
                end
                StLocked: begin
                    // Flywheel on our own prediction so one corrupt word cannot reseed us.
                    w_expected_d = nxt(r_expected);
                    if (io_bus.din == r_expected) begin
                        w_bad_run_d = '0;
                    end else begin
                        w_err_d     = 1'b1;
                        w_count_err = 1'b1;
                        if (r_bad_run == BAD_LAST) begin
                            w_bad_run_d = '0;
                            w_locked_d  = 1'b0;
                            w_state_d   = StSearch;
                        end else begin
                            w_bad_run_d = r_bad_run + BAD_ONE;
                        end
                    end
                end
                default: w_state_d = StSearch;
            endcase
        end

        // Clear applies first so a coincident counted error leaves the count at one.
        w_cnt_base    = io_bus.clear_cnt ? '0 : r_err_count;
        w_err_count_d = w_cnt_base;
        if (w_count_err && (w_cnt_base != CNT_MAX)) begin
            w_err_count_d = w_cnt_base + CNT_ONE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StSearch;
            r_expected  <= '0;
            r_match_cnt <= '0;
            r_bad_run   <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_d;
            r_expected  <= w_expected_d;
            r_match_cnt <= w_match_cnt_d;
            r_bad_run   <= w_bad_run_d;
            r_locked    <= w_locked_d;
            r_err       <= w_err_d;
            r_err_count <= w_err_count_d;
        end
    end

    assign io_bus.locked    = r_locked;
    assign io_bus.err       = r_err;
    assign io_bus.err_count = r_err_count;
    assign io_bus.expected  = r_expected;
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed table-driven bench: default checker (A) plus a CNT_W=2 checker (B) for saturation.
module tb_lfsr_checker;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lfsr_checker_if #(.WIDTH(4), .CNT_W(8)) if_a ();
    lfsr_checker_if #(.WIDTH(4), .CNT_W(2)) if_b ();

    lfsr_checker #(.WIDTH(4), .TAPS(4'b1100), .LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(8)) u_dut_a (
        .i_clk  (clk),
        .i_rst  (rst_a),
        .io_bus (if_a.slave)
    );

    lfsr_checker #(.WIDTH(4), .TAPS(4'b1100), .LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(2)) u_dut_b (
        .i_clk  (clk),
        .i_rst  (rst_b),
        .io_bus (if_b.slave)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [3:0] din;
        logic       clr;
        logic       lck;
        logic       err;
        logic [7:0] cnt;
        logic [3:0] exp;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] d, input logic c,
                                input logic l, input logic e, input logic [7:0] n,
                                input logic [3:0] x);
        vec_t t;
        t.rst = r; t.vld = v; t.din = d; t.clr = c;
        t.lck = l; t.err = e; t.cnt = n; t.exp = x;
        return t;
    endfunction

    task automatic chk(input string name, input int sel, input int idx,
                       input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut=%0d vec=%0d got=%0h want=%0h", name, sel, idx, act, req);
        end
    endtask

    task automatic check_outs(input int sel, input int idx, input vec_t v);
        logic       l, e;
        logic [7:0] n;
        logic [3:0] x;
        if (sel == 0) begin
            l = if_a.locked; e = if_a.err; n = if_a.err_count; x = if_a.expected;
        end else begin
            l = if_b.locked; e = if_b.err; n = {6'd0, if_b.err_count}; x = if_b.expected;
        end
        chk("locked", sel, idx, {7'd0, l}, {7'd0, v.lck});
        chk("err", sel, idx, {7'd0, e}, {7'd0, v.err});
        chk("err_count", sel, idx, n, v.cnt);
        chk("expected", sel, idx, {4'd0, x}, {4'd0, v.exp});
    endtask

    // Drive at the falling edge; reset vectors are checked before any rising edge.
    task automatic apply(input int sel, input int idx, input vec_t v);
        @(negedge clk);
        if (sel == 0) begin
            rst_a = v.rst; if_a.din_valid = v.vld; if_a.din = v.din; if_a.clear_cnt = v.clr;
        end else begin
            rst_b = v.rst; if_b.din_valid = v.vld; if_b.din = v.din; if_b.clear_cnt = v.clr;
        end
        if (!v.rst) @(posedge clk);
        #1;
        check_outs(sel, idx, v);
    endtask

    initial begin
        if_a.din_valid = 1'b0; if_a.din = 4'd0; if_a.clear_cnt = 1'b0;
        if_b.din_valid = 1'b0; if_b.din = 4'd0; if_b.clear_cnt = 1'b0;

        // Zero in search, acquire, single error, idle, clear alone
        tab_a.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0, 4'b0000));
        tab_a.push_back(mk(0, 1, 4'b1111, 0, 0, 0, 0, 4'b1110));
        tab_a.push_back(mk(0, 1, 4'b1110, 0, 0, 0, 0, 4'b1100));
        tab_a.push_back(mk(0, 1, 4'b1100, 0, 0, 0, 0, 4'b1000));
        tab_a.push_back(mk(0, 1, 4'b1000, 0, 0, 0, 0, 4'b0001));
        tab_a.push_back(mk(0, 1, 4'b0001, 0, 1, 0, 0, 4'b0010));
        tab_a.push_back(mk(0, 1, 4'b0000, 0, 1, 1, 1, 4'b0100));
        tab_a.push_back(mk(0, 1, 4'b0100, 0, 1, 0, 1, 4'b1001));
        tab_a.push_back(mk(0, 1, 4'b1001, 0, 1, 0, 1, 4'b0011));
        tab_a.push_back(mk(0, 0, 4'b1111, 0, 1, 0, 1, 4'b0011));
        tab_a.push_back(mk(0, 0, 4'b1111, 1, 1, 0, 0, 4'b0011));
        // Three bad words unlock, then relock from seed 0001
        tab_a.push_back(mk(0, 1, 4'b0000, 0, 1, 1, 1, 4'b0110));
        tab_a.push_back(mk(0, 1, 4'b0000, 0, 1, 1, 2, 4'b1101));
        tab_a.push_back(mk(0, 1, 4'b0000, 0, 0, 1, 3, 4'b1010));
        tab_a.push_back(mk(0, 1, 4'b0001, 0, 0, 0, 3, 4'b0010));
        tab_a.push_back(mk(0, 1, 4'b0010, 0, 0, 0, 3, 4'b0100));
        tab_a.push_back(mk(0, 1, 4'b0100, 0, 0, 0, 3, 4'b1001));
        tab_a.push_back(mk(0, 1, 4'b1001, 0, 0, 0, 3, 4'b0011));
        tab_a.push_back(mk(0, 1, 4'b0011, 0, 1, 0, 3, 4'b0110));
        // Async reset while locked, then acquire with valid gaps
        tab_a.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000));
        tab_a.push_back(mk(0, 1, 4'b1111, 0, 0, 0, 0, 4'b1110));
        tab_a.push_back(mk(0, 0, 4'b0101, 0, 0, 0, 0, 4'b1110));
        tab_a.push_back(mk(0, 1, 4'b1110, 0, 0, 0, 0, 4'b1100));
        tab_a.push_back(mk(0, 0, 4'b0101, 0, 0, 0, 0, 4'b1100));
        tab_a.push_back(mk(0, 1, 4'b1100, 0, 0, 0, 0, 4'b1000));
        tab_a.push_back(mk(0, 0, 4'b0101, 0, 0, 0, 0, 4'b1000));
        tab_a.push_back(mk(0, 1, 4'b1000, 0, 0, 0, 0, 4'b0001));
        tab_a.push_back(mk(0, 0, 4'b0101, 0, 0, 0, 0, 4'b0001));
        tab_a.push_back(mk(0, 1, 4'b0001, 0, 1, 0, 0, 4'b0010));
        tab_a.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 0, 4'b0010));
        // Verify-state reseed and zero drop to search: never an error while unlocked
        tab_a.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000));
        tab_a.push_back(mk(0, 1, 4'b0011, 0, 0, 0, 0, 4'b0110));
        tab_a.push_back(mk(0, 1, 4'b0101, 0, 0, 0, 0, 4'b1011));
        tab_a.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0, 4'b1011));
        tab_a.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0, 4'b1011));
        tab_a.push_back(mk(0, 1, 4'b1011, 0, 0, 0, 0, 4'b0111));

        // CNT_W=2: lock, five interleaved errors saturate at 3, then clear interplay
        tab_b.push_back(mk(0, 1, 4'b1111, 0, 0, 0, 0, 4'b1110));
        tab_b.push_back(mk(0, 1, 4'b1110, 0, 0, 0, 0, 4'b1100));
        tab_b.push_back(mk(0, 1, 4'b1100, 0, 0, 0, 0, 4'b1000));
        tab_b.push_back(mk(0, 1, 4'b1000, 0, 0, 0, 0, 4'b0001));
        tab_b.push_back(mk(0, 1, 4'b0001, 0, 1, 0, 0, 4'b0010));
        tab_b.push_back(mk(0, 1, 4'b0000, 0, 1, 1, 1, 4'b0100));
        tab_b.push_back(mk(0, 1, 4'b0100, 0, 1, 0, 1, 4'b1001));
        tab_b.push_back(mk(0, 1, 4'b0000, 0, 1, 1, 2, 4'b0011));
        tab_b.push_back(mk(0, 1, 4'b0011, 0, 1, 0, 2, 4'b0110));
        tab_b.push_back(mk(0, 1, 4'b0000, 0, 1, 1, 3, 4'b1101));
        tab_b.push_back(mk(0, 1, 4'b1101, 0, 1, 0, 3, 4'b1010));
        tab_b.push_back(mk(0, 1, 4'b0000, 0, 1, 1, 3, 4'b0101));
        tab_b.push_back(mk(0, 1, 4'b0101, 0, 1, 0, 3, 4'b1011));
        tab_b.push_back(mk(0, 1, 4'b0000, 0, 1, 1, 3, 4'b0111));
        tab_b.push_back(mk(0, 1, 4'b0111, 0, 1, 0, 3, 4'b1111));
        tab_b.push_back(mk(0, 1, 4'b0000, 1, 1, 1, 1, 4'b1110));
        tab_b.push_back(mk(0, 1, 4'b1110, 1, 1, 0, 0, 4'b1100));
        tab_b.push_back(mk(0, 0, 4'b0000, 0, 1, 0, 0, 4'b1100));

        #2;
        check_outs(0, -1, mk(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000));
        check_outs(1, -1, mk(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000));

        for (int i = 0; i < tab_a.size(); i++) apply(0, i, tab_a[i]);
        for (int i = 0; i < tab_b.size(); i++) apply(1, i, tab_b[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
